// File: rtl/fb_scan_reader_if.sv
// Frame buffer port B plus pixel stream bundle for fb_scan_reader.
// master = the scan reader; slave = the buffer and the video output stage.
interface fb_scan_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] adb;
  logic              ceb;
  logic              oce;
  logic              resetb;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_eol;
  logic              pix_eof;

  modport master (
    output adb, ceb, oce, resetb, pix_data, pix_valid, pix_eol, pix_eof,
    input  dout, pix_ready
  );

  modport slave (
    input  adb, ceb, oce, resetb, pix_data, pix_valid, pix_eol, pix_eof,
    output dout, pix_ready
  );
endinterface

// File: rtl/fb_scan_reader.sv
// Raster-order frame scanner: issues port B reads, streams pixels out through a 3-deep skid FIFO.
// Optional FB_SCAN_READER_MIRROR_X_EN adds mirror_x (horizontally mirrored addressing).
module fb_scan_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
`ifdef FB_SCAN_READER_MIRROR_X_EN
  input  logic              mirror_x,
`endif
  output logic              busy,
  fb_scan_reader_if.master  fb
);

  localparam int XW     = $clog2(WIDTH + 1);
  localparam int YW     = $clog2(HEIGHT + 1);
  localparam int STAGES = 0;
  localparam int DEPTH  = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              eol;
    logic              eof;
  } pix_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] row_addr;
  logic [XW-1:0]     x, x_eff;
  logic [YW-1:0]     y;
  logic              mir;
  logic              x_last, y_last;
  logic              accept, issue, push, pop;

  logic [STAGES:0]   vld_pipe;
  logic [1:0]        tag_pipe;

  pix_t [DEPTH-1:0]  fifo_mem;
  pix_t              head;
  logic [1:0]        wr_ptr, rd_ptr, fifo_cnt;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign x_last = (x == XW'(WIDTH - 1));
  assign y_last = (y == YW'(HEIGHT - 1));
  assign x_eff  = mir ? (XW'(WIDTH - 1) - x) : x;
  assign accept = (state == S_IDLE) && start;

  // Credit check uses only registered occupancy, so pix_ready never reaches ceb.
  assign issue  = (state == S_ISSUE) &&
                  (({1'b0, fifo_cnt} + {2'b00, vld_pipe[0]}) < 3'(DEPTH));
  assign push   = vld_pipe[0];
  assign head   = fifo_mem[rd_ptr];
  assign pop    = fb.pix_valid && fb.pix_ready;

  assign fb.ceb       = issue;
  assign fb.adb       = (state == S_ISSUE) ? (row_addr + ADDR_W'(x_eff)) : '0;
  assign fb.oce       = 1'b1;
  assign fb.resetb    = 1'b0;
  assign fb.pix_valid = (fifo_cnt != 2'd0);
  assign fb.pix_data  = fb.pix_valid ? head.data : '0;
  assign fb.pix_eol   = fb.pix_valid && head.eol;
  assign fb.pix_eof   = fb.pix_valid && head.eof;
  assign busy         = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (issue && x_last && y_last) state_nx = S_DRAIN;
      S_DRAIN: if (pop && head.eof) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

`ifdef FB_SCAN_READER_MIRROR_X_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     mir <= 1'b0;
    else if (accept) mir <= mirror_x;
  end
`else
  assign mir = 1'b0;
`endif

  // Scan position; row_addr accumulates frame_base + y*WIDTH without a multiplier.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_addr <= '0;
      x        <= '0;
      y        <= '0;
    end else if (accept) begin
      row_addr <= frame_base;
      x        <= '0;
      y        <= '0;
    end else if (issue) begin
      if (x_last) begin
        x        <= '0;
        y        <= y + YW'(1);
        row_addr <= row_addr + ADDR_W'(WIDTH);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Tags travel alongside the read so they line up with dout one cycle later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      tag_pipe    <= {x_last, x_last && y_last};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{data: fb.dout, eol: tag_pipe[1], eof: tag_pipe[0]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader at WIDTH=4, HEIGHT=2: vector table of frames plus reset sequence.
module tb_fb_scan_reader;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
`ifdef FB_SCAN_READER_MIRROR_X_EN
  localparam int NV = 7;
`else
  localparam int NV = 6;
`endif

  typedef struct {
    logic [AW-1:0] base;
    bit            rnd_ready;
    int            start_mode;  // 0 none, 1 extra start mid-frame, 2 extra start with eof
    bit            mir;
    logic [7:0]    first_pix;
    logic [7:0]    last_pix;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          busy;
`ifdef FB_SCAN_READER_MIRROR_X_EN
  logic          mirror_x = 1'b0;
`endif
  int errors = 0;
  int checks = 0;
  vec_t vecs [NV];

  fb_scan_reader_if #(.ADDR_W(AW), .DATA_W(DW)) fb ();

  fb_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .frame_base (frame_base),
`ifdef FB_SCAN_READER_MIRROR_X_EN
    .mirror_x   (mirror_x),
`endif
    .busy       (busy),
    .fb         (fb.master)
  );

  always #5 clk = ~clk;

  // Frame buffer model: every address holds its low byte, one-cycle read latency.
  always @(posedge clk) if (fb.ceb) fb.dout <= fb.adb[7:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input bit mir, input int k);
    int px = k % W;
    int py = k / W;
    int xe = mir ? (W - 1 - px) : px;
    return AW'(int'(base) + py * W + xe);
  endfunction

  task automatic run_frame(input vec_t v);
    int issued = 0, xfers = 0, cyc = 0, first_ceb = -1, first_vld = -1, max_out = 0;
    logic [7:0] first_got = '0, last_got = '0, held = '0;
    bit stalled = 0, done = 0;
    logic [AW-1:0] ea;

    @(negedge clk);
    frame_base = v.base;
    start = 1'b1;
    fb.pix_ready = 1'b1;
`ifdef FB_SCAN_READER_MIRROR_X_EN
    mirror_x = v.mir;
`endif
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      frame_base = '0;
`ifdef FB_SCAN_READER_MIRROR_X_EN
      mirror_x = ~v.mir;
`endif
      if (v.start_mode == 1 && cyc == 5) begin
        start = 1'b1;
        frame_base = 12'h100;
      end
      fb.pix_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.start_mode == 2 && fb.pix_valid && fb.pix_ready && fb.pix_eof) begin
        start = 1'b1;
        frame_base = 12'h200;
      end

      if (stalled) begin
        check("stall_valid", fb.pix_valid, 1);
        check("stall_data", fb.pix_data, held);
      end
      if (fb.ceb) begin
        if (first_ceb < 0) first_ceb = cyc;
        ea = exp_addr(v.base, v.mir, issued);
        check($sformatf("adb[%0d]", issued), fb.adb, ea);
        issued++;
      end
      if (issued - xfers > max_out) max_out = issued - xfers;
      if (fb.pix_valid && first_vld < 0) first_vld = cyc;
      if (fb.pix_valid && fb.pix_ready) begin
        ea = exp_addr(v.base, v.mir, xfers);
        check($sformatf("pix[%0d]", xfers), fb.pix_data, ea[7:0]);
        check($sformatf("eol[%0d]", xfers), fb.pix_eol, (xfers % W) == W - 1);
        check($sformatf("eof[%0d]", xfers), fb.pix_eof, xfers == N - 1);
        if (xfers == 0) first_got = fb.pix_data;
        last_got = fb.pix_data;
        if (fb.pix_eof) begin
          done = 1;
          check("busy_at_eof", busy, 1);
        end
        xfers++;
      end
      stalled = fb.pix_valid && !fb.pix_ready;
      held = fb.pix_data;
    end
    start = 1'b0;
    check("frame_done", done, 1);
    check("first_ceb_cycle", first_ceb, 1);
    check("first_valid_cycle", first_vld, 3);
    check("first_pixel", first_got, v.first_pix);
    check("last_pixel", last_got, v.last_pix);
    check("xfer_count", xfers, N);
    check("outstanding_le3", max_out <= 3, 1);

    fb.pix_ready = 1'b1;
    @(negedge clk);
    check("busy_drop", busy, 0);
    begin
      int extra = 0;
      repeat (6) begin
        if (fb.ceb || fb.pix_valid || busy) extra++;
        if (fb.ceb) issued++;
        @(negedge clk);
      end
      check("no_second_frame", extra, 0);
    end
    check("issue_count", issued, N);
  endtask

  initial begin
    logic [AW-1:0] rb;
    vec_t vr;
    int n;
    fb.pix_ready = 1'b1;
    rb = AW'($urandom);
    vecs[0] = '{12'h010, 1'b0, 0, 1'b0, 8'h10, 8'h17};
    vecs[1] = '{12'h010, 1'b1, 0, 1'b0, 8'h10, 8'h17};
    vecs[2] = '{12'hFFE, 1'b1, 0, 1'b0, 8'hFE, 8'h05};
    vecs[3] = '{12'h040, 1'b0, 1, 1'b0, 8'h40, 8'h47};
    vecs[4] = '{12'h0A0, 1'b1, 2, 1'b0, 8'hA0, 8'hA7};
    vecs[5] = '{rb, 1'b1, 0, 1'b0, rb[7:0], 8'(rb + 12'd7)};
`ifdef FB_SCAN_READER_MIRROR_X_EN
    vecs[6] = '{12'h000, 1'b1, 0, 1'b1, 8'h03, 8'h04};
`endif

    #12;
    check("reset_outputs",
          {fb.adb, fb.ceb, fb.pix_valid, fb.pix_data, fb.pix_eol, fb.pix_eof, busy}, 0);
    check("oce_resetb", {fb.oce, fb.resetb}, 2'b10);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) run_frame(vecs[i]);

    // Reset mid-frame after the third transfer, then a clean frame from base 0.
    @(negedge clk);
    frame_base = 12'h300;
    start = 1'b1;
    fb.pix_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (fb.pix_valid && fb.pix_ready) n++;
    end
    check("pre_reset_xfers", n, 3);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midframe_reset_outputs",
          {fb.adb, fb.ceb, fb.pix_valid, fb.pix_data, fb.pix_eol, fb.pix_eof, busy}, 0);
    @(negedge clk);
    check("held_reset_outputs", {fb.ceb, fb.pix_valid, busy}, 0);
    resetn = 1'b1;
    vr = '{12'h000, 1'b0, 0, 1'b0, 8'h00, 8'h07};
    run_frame(vr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
